// File: rtl/wptr_full_gen.sv
// wptr_full_gen
//   Write-domain half of an asynchronous FIFO. Keeps the binary and Gray write
//   pointers and brings the read-domain Gray pointer into w_clk through a
//   two-flop synchroniser. From these it produces registered full, almost_full,
//   fill level and overflow indications. Single clock domain (w_clk).
//
// Ports
//   w_clk        in   write clock
//   w_rst        in   asynchronous reset, active-high
//   w_en         in   write request from the producer
//   r_ptr_gray   in   read pointer, Gray coded, from the r_clk domain (async)
//   w_ptr        out  binary write pointer; [PTR_WIDTH-1:0] is the RAM address
//   w_ptr_gray   out  registered Gray write pointer for the read-side synchroniser
//   full         out  FIFO full, registered
//   almost_full  out  level >= AF_THRESH, registered
//   w_level      out  occupied entries as seen from the write domain (0..DEPTH)
//   w_ack        out  write accepted this cycle (w_en && !full), combinational
//   overflow     out  one-cycle pulse, registered: a write was attempted while full
//
// Handshake: w_en is a request with no hold requirement; a write happens on the
// rising edge of w_clk for which w_ack is high. A write seen while full is
// dropped and reported on overflow in the following cycle.

module wptr_full_gen #(
  parameter int PTR_WIDTH = 3,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   r_ptr_gray,
  output logic [PTR_WIDTH:0]   w_ptr,
  output logic [PTR_WIDTH:0]   w_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   w_level,
  output logic                 w_ack,
  output logic                 overflow
);

  localparam int              P      = PTR_WIDTH;
  localparam logic [P:0]      AF_LVL = (P + 1)'(AF_THRESH);
  localparam logic [P:0]      PTR_ONE = (P + 1)'(1);

  if (PTR_WIDTH < 2) begin : g_bad_width
    $error("wptr_full_gen: PTR_WIDTH must be at least 2");
  end
  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("wptr_full_gen: DEPTH must equal 2**PTR_WIDTH");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("wptr_full_gen: AF_THRESH must be in 1..DEPTH");
  end

  logic [P:0] w_ptr_q, w_ptr_d;
  logic [P:0] gray_q, gray_d;
  logic [P:0] rq1_q, rq2_q;
  logic [P:0] r_bin_sync;
  logic [P:0] level_q, level_d;
  logic       full_q, full_d;
  logic       af_q, af_d;
  logic       ovf_q, ovf_d;

  // Writes are refused while full, so the pointers cannot overrun the reader.
  assign w_ack = w_en & ~full_q;

  // Gray to binary: bit i of the binary value is the XOR of all Gray bits >= i.
  always_comb begin
    r_bin_sync = '0;
    for (int i = 0; i <= P; i++) begin
      r_bin_sync[i] = ^(rq2_q >> i);
    end
  end

  always_comb begin
    w_ptr_d = w_ptr_q;
    if (w_ack) begin
      w_ptr_d = w_ptr_q + PTR_ONE;
    end
    gray_d  = w_ptr_d ^ (w_ptr_d >> 1);
    // Full when the next write pointer has lapped the synchronised read
    // pointer once: in Gray code that is the top two bits inverted and the
    // remaining bits equal.
    full_d  = (gray_d == {~rq2_q[P:P-1], rq2_q[P-2:0]});
    // Level uses the already-synchronised read pointer, so it can only
    // overstate occupancy, never understate it.
    level_d = w_ptr_d - r_bin_sync;
    af_d    = (level_d >= AF_LVL);
    ovf_d   = w_en & full_q;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_ptr_q <= '0;
      gray_q  <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      gray_q  <= gray_d;
      // Plain two-flop synchroniser; nothing may sit between rq1 and rq2.
      rq1_q   <= r_ptr_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_ptr       = w_ptr_q;
  assign w_ptr_gray  = gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign w_level     = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
module tb_wptr_full_gen;

  // ---------------- clock / reset / DUT ----------------
  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       w_en;
  logic [3:0] r_ptr_gray;
  logic [3:0] w_ptr;
  logic [3:0] w_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] w_level;
  logic       w_ack;
  logic       overflow;

  always #5 w_clk = ~w_clk;

  wptr_full_gen #(.PTR_WIDTH(3), .DEPTH(8), .AF_THRESH(6)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_en        (w_en),
    .r_ptr_gray  (r_ptr_gray),
    .w_ptr       (w_ptr),
    .w_ptr_gray  (w_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .w_level     (w_level),
    .w_ack       (w_ack),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Expected post-edge state: {ptr, gray, full, almost_full, level, overflow}
  logic [14:0] exp_q[$];

  typedef struct {
    logic       w_en;
    logic [3:0] r_gray;
    logic       e_ack;
    logic [3:0] e_ptr;
    logic [3:0] e_gray;
    logic       e_full;
    logic       e_af;
    logic [3:0] e_level;
    logic       e_ovf;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic en, input logic [3:0] rg, input logic ack,
                              input logic [3:0] ptr, input logic [3:0] gr, input logic fl,
                              input logic af, input logic [3:0] lvl, input logic ovf);
    vec_t v;
    v.w_en = en; v.r_gray = rg; v.e_ack = ack; v.e_ptr = ptr; v.e_gray = gr;
    v.e_full = fl; v.e_af = af; v.e_level = lvl; v.e_ovf = ovf;
    return v;
  endfunction

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    w_en       = 1'b0;
    r_ptr_gray = 4'd0;
    w_rst      = 1'b1;
    repeat (2) @(posedge w_clk);
    #1 w_rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ptr"},   w_ptr,       4'd0);
    chk({tag, "_gray"},  w_ptr_gray,  4'd0);
    chk({tag, "_full"},  {3'd0, full},        4'd0);
    chk({tag, "_af"},    {3'd0, almost_full}, 4'd0);
    chk({tag, "_level"}, w_level,     4'd0);
    chk({tag, "_ovf"},   {3'd0, overflow},    4'd0);
    chk({tag, "_ack"},   {3'd0, w_ack},       4'd0);
  endtask

  // ---------------- Gray one-bit-step monitor ----------------
  logic [3:0] last_gray;
  logic       ack_pend;
  bit         mon_valid = 1'b0;

  always @(negedge w_clk) begin
    if (w_rst) begin
      mon_valid = 1'b0;
    end else begin
      if (mon_valid) begin
        checks++;
        if (ack_pend) begin
          if ($countones(last_gray ^ w_ptr_gray) != 1) begin
            errors++;
            $display("FAIL gray_step: got %0h after %0h, one bit change required",
                     w_ptr_gray, last_gray);
          end
        end else if (w_ptr_gray !== last_gray) begin
          errors++;
          $display("FAIL gray_hold: got %0h expected %0h", w_ptr_gray, last_gray);
        end
      end
      mon_valid = 1'b1;
      last_gray = w_ptr_gray;
      ack_pend  = w_ack;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [14:0] e;

    // fill 8, overflow 3, read advance seen after 3 edges, refill, overflow once
    vecs[0]  = mk(1, 4'h0, 1, 4'h1, 4'b0001, 0, 0, 4'd1, 0);
    vecs[1]  = mk(1, 4'h0, 1, 4'h2, 4'b0011, 0, 0, 4'd2, 0);
    vecs[2]  = mk(1, 4'h0, 1, 4'h3, 4'b0010, 0, 0, 4'd3, 0);
    vecs[3]  = mk(1, 4'h0, 1, 4'h4, 4'b0110, 0, 0, 4'd4, 0);
    vecs[4]  = mk(1, 4'h0, 1, 4'h5, 4'b0111, 0, 0, 4'd5, 0);
    vecs[5]  = mk(1, 4'h0, 1, 4'h6, 4'b0101, 0, 1, 4'd6, 0);
    vecs[6]  = mk(1, 4'h0, 1, 4'h7, 4'b0100, 0, 1, 4'd7, 0);
    vecs[7]  = mk(1, 4'h0, 1, 4'h8, 4'b1100, 1, 1, 4'd8, 0);
    vecs[8]  = mk(1, 4'h0, 0, 4'h8, 4'b1100, 1, 1, 4'd8, 1);
    vecs[9]  = mk(1, 4'h0, 0, 4'h8, 4'b1100, 1, 1, 4'd8, 1);
    vecs[10] = mk(1, 4'h0, 0, 4'h8, 4'b1100, 1, 1, 4'd8, 1);
    vecs[11] = mk(0, 4'h0, 0, 4'h8, 4'b1100, 1, 1, 4'd8, 0);
    vecs[12] = mk(0, 4'h1, 0, 4'h8, 4'b1100, 1, 1, 4'd8, 0);
    vecs[13] = mk(0, 4'h1, 0, 4'h8, 4'b1100, 1, 1, 4'd8, 0);
    vecs[14] = mk(0, 4'h1, 0, 4'h8, 4'b1100, 0, 1, 4'd7, 0);
    vecs[15] = mk(1, 4'h1, 1, 4'h9, 4'b1101, 1, 1, 4'd8, 0);
    vecs[16] = mk(1, 4'h1, 0, 4'h9, 4'b1101, 1, 1, 4'd8, 1);
    vecs[17] = mk(0, 4'h1, 0, 4'h9, 4'b1101, 1, 1, 4'd8, 0);

    w_rst      = 1'b0;
    w_en       = 1'b0;
    r_ptr_gray = 4'd0;
    #1;
    do_reset();
    check_zero("reset");

    // Table: drive, check combinational ack, push expectation, pop after edge.
    for (int i = 0; i < NVEC; i++) begin
      w_en       = vecs[i].w_en;
      r_ptr_gray = vecs[i].r_gray;
      #1;
      chk($sformatf("v%0d_ack", i), {3'd0, w_ack}, {3'd0, vecs[i].e_ack});
      exp_q.push_back({vecs[i].e_ptr, vecs[i].e_gray, vecs[i].e_full, vecs[i].e_af,
                       vecs[i].e_level, vecs[i].e_ovf});
      @(posedge w_clk);
      #1;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL v%0d_queue: got empty queue expected one entry", i);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_ptr", i),   w_ptr,              e[14:11]);
        chk($sformatf("v%0d_gray", i),  w_ptr_gray,         e[10:7]);
        chk($sformatf("v%0d_full", i),  {3'd0, full},        {3'd0, e[6]});
        chk($sformatf("v%0d_af", i),    {3'd0, almost_full}, {3'd0, e[5]});
        chk($sformatf("v%0d_level", i), w_level,            e[4:1]);
        chk($sformatf("v%0d_ovf", i),   {3'd0, overflow},    {3'd0, e[0]});
      end
    end

    // Asynchronous reset mid-stream with w_ptr = 5.
    do_reset();
    w_en = 1'b1;
    repeat (5) begin
      @(posedge w_clk);
      #1;
    end
    chk("midrst_pre_ptr", w_ptr, 4'd5);
    #2;
    w_rst = 1'b1;
    w_en  = 1'b0;
    #1;
    check_zero("midrst");
    do_reset();

    // Wrap: read pointer follows the write Gray pointer four cycles late.
    for (int j = 1; j <= 40; j++) begin
      r_ptr_gray = (j >= 5) ? g4(4'(j - 4)) : 4'd0;
      w_en       = 1'b1;
      #1;
      chk($sformatf("wrap%0d_ack", j), {3'd0, w_ack}, 4'd1);
      @(posedge w_clk);
      #1;
      chk($sformatf("wrap%0d_ptr", j),   w_ptr,              4'(j));
      chk($sformatf("wrap%0d_full", j),  {3'd0, full},        4'd0);
      chk($sformatf("wrap%0d_level", j), w_level,            (j < 6) ? 4'(j) : 4'd6);
      chk($sformatf("wrap%0d_af", j),    {3'd0, almost_full}, (j >= 6) ? 4'd1 : 4'd0);
    end
    w_en = 1'b0;
    @(posedge w_clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
